serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Serial frame receiver that consumes the registered single-bit stream produced by the D flip-flop stage, recognises start/data/parity/stop framing, and presents each received word on a parallel valid/ready interface. It sits directly downstream of the flip-flop stage, which retimes the raw serial line, and upstream of any word-level consumer. A one-entry holding buffer decouples frame reception from consumer back-pressure.

## Interface
- DATA_W, 8, data bits per frame (2..16)
- PARITY_EN, 1, 1 = even parity bit present between data and stop; 0 = no parity bit
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-low reset
- din  input  1  serial bit from the flip-flop stage; idles high
- en  input  1  bit strobe; din is sampled only on edges where en = 1
- dout  output  DATA_W  received word, LSB first on the line
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
- parity_err  output  1  parity status of the word on dout; qualified by dout_valid
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0, frame dropped
- overrun  output  1  one-cycle pulse: valid frame completed while the buffer was full, frame dropped
- busy  output  1  receiver is in any state other than IDLE

## Operation
- Frame format: start bit 0, DATA_W data bits LSB first, parity bit if PARITY_EN, stop bit 1.
- States and transitions (all require en = 1; with en = 0 the state, counter, and shift register hold):
  - IDLE: din = 0 -> DATA, bit_cnt = 0.
  - DATA: shift din into the MSB of shift_reg, which shifts right, and increment bit_cnt. When bit_cnt = DATA_W-1, go to PARITY if PARITY_EN, else go to STOP.
  - PARITY: capture din into par_bit, then go to STOP.
  - STOP: din = 1 -> deliver the frame, then go to IDLE. din = 0 -> frame_err pulse, discard the frame, go to IDLE.
- Parity: even. parity_err = XOR of shift_reg and par_bit. When PARITY_EN = 0, parity_err = 0.
- Delivery: the buffer loads when it is empty or is being drained on the same edge (dout_valid && dout_ready). Loading sets dout, parity_err and dout_valid = 1.
- Buffer full and not draining: the frame is dropped, overrun pulses, and dout and parity_err are unchanged.
- A frame with a parity error is still delivered, with parity_err = 1.
- Handshake: dout and parity_err stay stable while dout_valid && !dout_ready. dout_valid clears on acceptance unless a new word loads on the same edge.
- Reset (clr = 0, any time, including mid-frame):
  - state = IDLE, bit_cnt = 0, shift_reg = 0.
  - dout = 0, dout_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
  - Any partial frame is lost.

## Timing
- dout_valid rises on the same clk edge that samples a valid stop bit, so it is visible in the following cycle.
- Frame length is 2 + DATA_W + PARITY_EN strobed bits.
- Back-to-back frames: a start bit on the first en after the stop bit is accepted; no idle bit is required.
- frame_err and overrun are registered and high for exactly one cycle after the stop-bit edge.
- busy rises on the edge that samples the start bit and falls on the edge that samples the stop bit.
- Simultaneous accept and load: the new word replaces the old one, dout_valid stays 1, and no overrun is raised.

## Structure
- Package serial_frame_pkg contains:
  - the state typedef (IDLE, DATA, PARITY, STOP);
  - constants START_BIT = 1'b0 and STOP_BIT = 1'b1.
- Sub-module rx_hold_buf: a one-entry valid/ready register holding {parity_err, dout} that generates the overrun pulse.
- The FSM, shift register, and bit counter live in serial_frame_rx.

## Test plan
All scenarios use DATA_W = 8, PARITY_EN = 1, en = 1 every cycle unless stated.
- Reset: clr = 0 with din toggling -> dout = 0x00, and dout_valid, parity_err, frame_err, overrun and busy all 0.
- Good frame: 0xA5 (bits 1,0,1,0,0,1,0,1), parity 0, stop 1, dout_ready = 1 -> dout_valid for 1 cycle after the stop edge, dout = 0xA5, parity_err = 0.
- Parity error: 0xA5 with parity bit 1 -> dout = 0xA5, parity_err = 1, dout_valid = 1.
- Framing error: 0x3C with stop bit 0 -> frame_err pulses for 1 cycle, dout_valid stays 0, and the next good frame 0x3C is delivered.
- Back-pressure and overrun, with dout_ready = 0:
  - Send 0x3C then 0x81 -> dout holds 0x3C, and overrun pulses at the 0x81 stop edge.
  - Then raise dout_ready -> 0x3C is accepted once, and dout_valid falls.
- Strobe gaps and reset mid-frame:
  - en = 0 for 3 cycles between each bit of 0x5A -> dout = 0x5A.
  - clr = 0 after 4 data bits of a frame -> busy = 0 immediately, and the following full 0x5A frame is received correctly.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared types and framing constants for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Even parity over a word of up to 16 bits; unused upper bits must be zero.
    function automatic logic even_parity16(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_frame_rx_hold_buf.sv
// One-entry valid/ready holding register; flags overrun when a word arrives while full.
module rx_hold_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overrun
);

    logic [W-1:0] data_r;
    logic         valid_r;
    logic         overrun_r;
    logic         drain_s;

    // Consumer takes the current word on this edge.
    always_comb begin
        drain_s = 1'b0;
        if (valid_r && ready) begin
            drain_s = 1'b1;
        end else begin
            drain_s = 1'b0;
        end
    end

    // Load, drain and overrun bookkeeping; a load on a draining edge replaces the word.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_r    <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (load) begin
            if (!valid_r || drain_s) begin
                data_r    <= data_in;
                valid_r   <= 1'b1;
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= 1'b1;
            end
        end else begin
            overrun_r <= 1'b0;
            if (drain_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign data    = data_r;
    assign valid   = valid_r;
    assign overrun = overrun_r;

endmodule

// File: rtl/serial_frame_rx.sv
// Strobed serial frame receiver: start, LSB-first data, optional even parity, stop.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              din,
    input  logic              en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    state_t            state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic              par_bit_r;
    logic              frame_err_r;
    logic              busy_r;
    logic              load_s;
    logic              perr_s;
    logic [DATA_W:0]   buf_q_s;

    // A good stop bit hands the assembled word to the holding buffer on the same edge.
    always_comb begin
        load_s = 1'b0;
        perr_s = 1'b0;
        if (en && (state_r == STOP) && (din == STOP_BIT)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        if (PARITY_EN) begin
            perr_s = even_parity16(16'(shift_r)) ^ par_bit_r;
        end else begin
            perr_s = 1'b0;
        end
    end

    // Framing FSM with shift register, bit counter and registered status pulses.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r     <= IDLE;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            par_bit_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (en) begin
                case (state_r)
                    IDLE: begin
                        if (din == START_BIT) begin
                            state_r   <= DATA;
                            bit_cnt_r <= '0;
                            busy_r    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_r <= {din, shift_r[DATA_W-1:1]};
                        if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_r <= '0;
                            state_r   <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        par_bit_r <= din;
                        state_r   <= STOP;
                    end
                    STOP: begin
                        frame_err_r <= (din != STOP_BIT);
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    rx_hold_buf #(.W(DATA_W + 1)) u_hold_buf (
        .clk     (clk),
        .clr     (clr),
        .load    (load_s),
        .data_in ({perr_s, shift_r}),
        .ready   (dout_ready),
        .data    (buf_q_s),
        .valid   (dout_valid),
        .overrun (overrun)
    );

    assign dout       = buf_q_s[DATA_W-1:0];
    assign parity_err = buf_q_s[DATA_W];
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed table, corner sequences, random frames.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       din = 1'b1;
    logic       en = 1'b0;
    logic       dout_ready = 1'b1;
    logic [7:0] dout;
    logic       dout_valid, parity_err, frame_err, overrun, busy;

    int checks = 0;
    int errors = 0;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
        .clk(clk), .clr(clr), .din(din), .en(en),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic       pflip;
        logic       stop;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] word;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   exp_ferr_cnt = 0;
    int   got_ferr_cnt = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit; the line returns to idle with en low afterwards.
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) tick();
        din = b;
        en  = 1'b1;
        tick();
        en  = 1'b0;
        din = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic pflip, input logic stop,
                              input int gap, input logic ready_at_stop);
        logic p;
        p = (^w) ^ pflip;
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(w[i], gap);
        send_bit(p, gap);
        if (ready_at_stop) dout_ready = 1'b1;
        send_bit(stop, gap);
    endtask

    // Scoreboard for the random phase: every accepted word must match the model queue.
    always @(negedge clk) begin
        if (mon_en && clr) begin
            if (dout_valid && dout_ready) begin
                exp_t e;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_extra: got word %0h expected none", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_word", {8'd0, dout}, {8'd0, e.word});
                    check("rnd_perr", {15'd0, parity_err}, {15'd0, e.perr});
                end
            end
            if (frame_err) got_ferr_cnt++;
        end
    end

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with the line toggling.
        for (int i = 0; i < 4; i++) begin
            din = i[0];
            en  = 1'b1;
            tick();
        end
        check("rst_dout", {8'd0, dout}, 16'h0000);
        check("rst_flags", {11'd0, dout_valid, parity_err, frame_err, overrun, busy}, 16'h0000);
        en  = 1'b0;
        din = 1'b1;
        clr = 1'b1;
        tick();

        // Directed table with the consumer always ready.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].word, vecs[i].pflip, vecs[i].stop, 0, 1'b0);
            check("tbl_valid", {15'd0, dout_valid}, {15'd0, vecs[i].exp_valid});
            check("tbl_ferr", {15'd0, frame_err}, {15'd0, vecs[i].exp_ferr});
            check("tbl_busy", {15'd0, busy}, 16'd0);
            if (vecs[i].exp_valid) begin
                check("tbl_dout", {8'd0, dout}, {8'd0, vecs[i].word});
                check("tbl_perr", {15'd0, parity_err}, {15'd0, vecs[i].exp_perr});
            end
            tick();
            check("tbl_valid_drop", {15'd0, dout_valid}, 16'd0);
            check("tbl_ferr_drop", {15'd0, frame_err}, 16'd0);
        end

        // Back-pressure: second frame overruns, held word survives, then one acceptance.
        dout_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
        check("bp_first", {8'd0, dout}, 16'h003C);
        send_frame(8'h81, 1'b0, 1'b1, 0, 1'b0);
        check("bp_overrun", {15'd0, overrun}, 16'd1);
        check("bp_hold", {7'd0, dout_valid, dout}, 16'h013C);
        tick();
        check("bp_overrun_drop", {15'd0, overrun}, 16'd0);
        dout_ready = 1'b1;
        tick();
        check("bp_accept", {15'd0, dout_valid}, 16'd0);

        // Drain and load on the same edge: new word replaces old, no overrun.
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h96, 1'b1, 1'b1, 0, 1'b1);
        check("swap_word", {6'd0, dout_valid, parity_err, dout}, 16'h0396);
        check("swap_overrun", {15'd0, overrun}, 16'd0);
        tick();
        check("swap_drain", {15'd0, dout_valid}, 16'd0);

        // Strobe gaps between every bit.
        send_frame(8'h5A, 1'b0, 1'b1, 3, 1'b0);
        check("gap_word", {7'd0, dout_valid, dout}, 16'h015A);
        tick();

        // Reset in the middle of a frame.
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        check("mid_busy_pre", {15'd0, busy}, 16'd1);
        clr = 1'b0;
        #1;
        check("mid_busy_rst", {15'd0, busy}, 16'd0);
        tick();
        clr = 1'b1;
        tick();
        send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
        check("mid_word", {7'd0, dout_valid, dout}, 16'h015A);
        tick();

        // Random frames with random gaps, parity faults and stop faults.
        mon_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [7:0] w;
            logic       pf, st;
            w  = 8'($urandom);
            pf = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) != 0);
            if (st) exp_q.push_back('{w, pf});
            else    exp_ferr_cnt++;
            send_frame(w, pf, st, $urandom_range(0, 2), 1'b0);
        end
        repeat (3) tick();
        mon_en = 1'b0;
        check("rnd_left", 16'(exp_q.size()), 16'd0);
        check("rnd_ferr", 16'(got_ferr_cnt), 16'(exp_ferr_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
